// File: rtl/multi_cycle_datapath_pkg.sv
// Shared encodings between the multi-cycle datapath and its controller.
// Optional debug read port is enabled with DP_DEBUG_PORT_EN (see top/regfile).
package multi_cycle_datapath_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_A     = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_IMM       = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctl_e;

endpackage

// File: rtl/multi_cycle_datapath_regfile.sv
// 32x32 register file, two combinational reads, one synchronous write, x0 hardwired to zero.
// With DP_DEBUG_PORT_EN defined a third read port (dbg_raddr/dbg_rdata) is added.
module regfile
    import multi_cycle_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
`ifdef DP_DEBUG_PORT_EN
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
`endif
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [32];

    // NOTE: this array is cleared by reset, so it maps to flops rather than a RAM macro;
    // a RAM-backed file would need an explicit clearing sequence instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents: a same-cycle write is visible only next cycle.
    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

`ifdef DP_DEBUG_PORT_EN
    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];
`endif

endmodule

// File: rtl/multi_cycle_datapath.sv
// Multi-cycle RV32-style datapath: holding registers, regfile, inline ALU and immediate extender.
// Defining DP_DEBUG_PORT_EN adds a debug regfile read port (dbg_raddr/dbg_rdata).
module multi_cycle_datapath
    import multi_cycle_datapath_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      ImmSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic            AddrSrc,
    input  logic [2:0]      ALUControl,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic            MemWrite,
    input  logic            PCWrite,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            zero,
`ifdef DP_DEBUG_PORT_EN
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
`endif
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    logic [XLEN-1:0] pc, old_pc, ir, data, a, b, alu_out;
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;

    regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (ir[19:15]),
        .raddr2 (ir[24:20]),
        .rdata1 (rd1),
        .rdata2 (rd2),
`ifdef DP_DEBUG_PORT_EN
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
`endif
        .we     (RegWrite),
        .waddr  (ir[11:7]),
        .wdata  (result)
    );

    // NOTE: every always_comb assigns its outputs a default first, so no path leaves a latch.
    always_comb begin
        imm_ext = '0;
        case (ImmSrc)
            IMM_I:   imm_ext = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm_ext = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm_ext = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            IMM_U:   imm_ext = {ir[31:12], 12'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        src_a = '0;
        case (ALUSrcA)
            SRCA_PC:    src_a = pc;
            SRCA_OLDPC: src_a = old_pc;
            SRCA_A:     src_a = a;
            default:    src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        case (ALUSrcB)
            SRCB_B:    src_b = b;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = 32'd4;
            default:   src_b = '0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (ALUControl)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLL: alu_result = src_a << src_b[4:0];
            ALU_SRL: alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        result = '0;
        case (ResultSrc)
            RES_ALUOUT:    result = alu_out;
            RES_DATA:      result = data;
            RES_ALURESULT: result = alu_result;
            default:       result = imm_ext;
        endcase
    end

    // NOTE: state uses non-blocking assignments so OldPC samples the pre-edge PC
    // even when PCWrite and IRWrite fire on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            data    <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (PCWrite) begin
                pc <= result;
            end
            if (IRWrite) begin
                ir     <= mem_rdata;
                old_pc <= pc;
            end
            data    <= mem_rdata;
            a       <= rd1;
            b       <= rd2;
            alu_out <= alu_result;
        end
    end

    assign op        = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign zero      = (alu_result == '0);
    assign mem_addr  = AddrSrc ? result : pc;
    assign mem_wdata = b;
    assign mem_we    = MemWrite;

endmodule

// File: tb/tb_multi_cycle_datapath.sv
// Directed, table-driven bench for multi_cycle_datapath; internal state is observed
// through the memory address port by steering it via the result/address muxes.
module tb_multi_cycle_datapath;
    import multi_cycle_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ImmSrc, ALUControl;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic        AddrSrc, IRWrite, RegWrite, MemWrite, PCWrite;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic        zero;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef DP_DEBUG_PORT_EN
    logic [4:0]  dbg_raddr = 5'd0;
    logic [31:0] dbg_rdata;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    multi_cycle_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AddrSrc    (AddrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
`ifdef DP_DEBUG_PORT_EN
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
`endif
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        z;
        string       name;
    } alu_vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  isrc;
        logic [31:0] imm;
        string       name;
    } imm_vec_t;

    alu_vec_t alu_tab[13];
    imm_vec_t imm_tab[11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        ImmSrc = 3'd0; ALUSrcA = 2'd0; ALUSrcB = 2'd0; ResultSrc = 2'd0;
        AddrSrc = 1'b0; ALUControl = 3'd0;
        IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] instr);
        idle();
        mem_rdata = instr;
        IRWrite   = 1'b1;
        tick();
        IRWrite   = 1'b0;
    endtask

    // Value travels mem_rdata -> Data -> Result -> rd.
    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        load_ir({20'd0, rd, 7'h33});
        mem_rdata = val;
        tick();
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        tick();
        idle();
    endtask

    // rs -> A, then A + 0 routed onto mem_addr.
    task automatic read_reg(input logic [4:0] rs, output logic [31:0] val);
        load_ir({12'd0, rs, 3'd0, 5'd0, 7'h13});
        tick();
        ALUSrcA = SRCA_A; ALUSrcB = SRCB_ZERO; ALUControl = ALU_ADD;
        ResultSrc = RES_ALURESULT; AddrSrc = 1'b1;
        #1;
        val = mem_addr;
        idle();
    endtask

    task automatic fetch(input logic [31:0] instr);
        idle();
        mem_rdata = instr;
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ALUControl = ALU_ADD;
        ResultSrc = RES_ALURESULT;
        tick();
        idle();
        #1;
    endtask

    task automatic observe_old_pc(output logic [31:0] val);
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_ZERO; ALUControl = ALU_ADD;
        ResultSrc = RES_ALURESULT; AddrSrc = 1'b1;
        #1;
        val = mem_addr;
        idle();
    endtask

    initial begin
        logic [31:0] v;

        alu_tab[0]  = '{32'd5,         32'd7,         ALU_ADD, 32'd12,        1'b0, "add"};
        alu_tab[1]  = '{32'hFFFF_FFFF, 32'd1,         ALU_ADD, 32'd0,         1'b1, "add_wrap"};
        alu_tab[2]  = '{32'd5,         32'd7,         ALU_SUB, 32'hFFFF_FFFE, 1'b0, "sub_neg"};
        alu_tab[3]  = '{32'd5,         32'd5,         ALU_SUB, 32'd0,         1'b1, "sub_eq"};
        alu_tab[4]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 32'hF000_F000, 1'b0, "and"};
        alu_tab[5]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR,  32'hFFF0_FFF0, 1'b0, "or"};
        alu_tab[6]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR, 32'h0FF0_0FF0, 1'b0, "xor"};
        alu_tab[7]  = '{32'hFFFF_FFFF, 32'd1,         ALU_SLT, 32'd1,         1'b0, "slt_neg"};
        alu_tab[8]  = '{32'd1,         32'hFFFF_FFFF, ALU_SLT, 32'd0,         1'b1, "slt_pos"};
        alu_tab[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'd1,         1'b0, "slt_min"};
        alu_tab[10] = '{32'd1,         32'h0000_0025, ALU_SLL, 32'h0000_0020, 1'b0, "sll_mask"};
        alu_tab[11] = '{32'h8000_0000, 32'd31,        ALU_SRL, 32'd1,         1'b0, "srl_31"};
        alu_tab[12] = '{32'h8000_0000, 32'hFFFF_FFE4, ALU_SRL, 32'h0800_0000, 1'b0, "srl_mask"};

        imm_tab[0]  = '{32'hFFF0_0093, IMM_I,  32'hFFFF_FFFF, "imm_i"};
        imm_tab[1]  = '{32'hFE20_AE23, IMM_S,  32'hFFFF_FFFC, "imm_s"};
        imm_tab[2]  = '{32'h0020_8463, IMM_B,  32'h0000_0008, "imm_b_pos"};
        imm_tab[3]  = '{32'hFE20_8EE3, IMM_B,  32'hFFFF_FFFC, "imm_b_neg"};
        imm_tab[4]  = '{32'h0080_00EF, IMM_J,  32'h0000_0008, "imm_j_pos"};
        imm_tab[5]  = '{32'hFF9F_F06F, IMM_J,  32'hFFFF_FFF8, "imm_j_neg"};
        imm_tab[6]  = '{32'h1234_50B7, IMM_U,  32'h1234_5000, "imm_u"};
        imm_tab[7]  = '{32'h8000_00B7, IMM_U,  32'h8000_0000, "imm_u_neg"};
        imm_tab[8]  = '{32'hFFF0_0093, 3'b101, 32'd0,         "imm_101"};
        imm_tab[9]  = '{32'hFFF0_0093, 3'b110, 32'd0,         "imm_110"};
        imm_tab[10] = '{32'hFFF0_0093, 3'b111, 32'd0,         "imm_111"};

        // Reset with every control asserted.
        rst = 1'b0;
        ImmSrc = '1; ALUSrcA = '1; ALUSrcB = '1; ResultSrc = '1; AddrSrc = 1'b1;
        ALUControl = '1; IRWrite = 1'b1; RegWrite = 1'b1; MemWrite = 1'b1; PCWrite = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b1;
        idle();
        #1;
        check("rst_pc", mem_addr, 32'h0);
        check("rst_op", {25'd0, op}, 32'h0);
        check("rst_funct7", {25'd0, funct7}, 32'h0);
        check("rst_mem_we", {31'd0, mem_we}, 32'h0);
        check("rst_b", mem_wdata, 32'h0);
        check("rst_zero", {31'd0, zero}, 32'h1);
        ResultSrc = RES_ALUOUT; AddrSrc = 1'b1; #1;
        check("rst_aluout", mem_addr, 32'h0);
        ResultSrc = RES_DATA; #1;
        check("rst_data", mem_addr, 32'h0);
        idle();
        read_reg(5'd1, v);  check("rst_x1", v, 32'h0);
        read_reg(5'd31, v); check("rst_x31", v, 32'h0);

        // Fetch addi x1,x0,5 with PC, IR and OldPC all updating on one edge.
        fetch(32'h0050_0093);
        check("fetch_pc", mem_addr, 32'd4);
        check("fetch_op", {25'd0, op}, 32'h13);
        observe_old_pc(v);
        check("fetch_oldpc", v, 32'd0);
        tick();
        ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; ImmSrc = IMM_I; ALUControl = ALU_ADD;
        tick();
        idle();
        ResultSrc = RES_ALUOUT; RegWrite = 1'b1;
        tick();
        idle();
        read_reg(5'd1, v);  check("addi_x1", v, 32'd5);
        write_reg(5'd0, 32'd7);
        read_reg(5'd0, v);  check("x0_write", v, 32'd0);

        // Second fetch: OldPC must hold the pre-edge PC.
        fetch(32'h0020_8463);
        check("fetch2_pc", mem_addr, 32'd8);
        check("fetch2_op", {25'd0, op}, 32'h63);
        observe_old_pc(v);
        check("fetch2_oldpc", v, 32'd4);

        for (int i = 0; i < 13; i++) begin
            write_reg(5'd1, alu_tab[i].a);
            write_reg(5'd2, alu_tab[i].b);
            load_ir(32'h0020_8033);
            tick();
            ALUSrcA = SRCA_A; ALUSrcB = SRCB_B; ALUControl = alu_tab[i].ctl;
            ResultSrc = RES_ALURESULT; AddrSrc = 1'b1;
            #1;
            check({alu_tab[i].name, "_res"}, mem_addr, alu_tab[i].res);
            check({alu_tab[i].name, "_zero"}, {31'd0, zero}, {31'd0, alu_tab[i].z});
            idle();
        end

        for (int i = 0; i < 11; i++) begin
            load_ir(imm_tab[i].instr);
            ImmSrc = imm_tab[i].isrc; ResultSrc = RES_IMM; AddrSrc = 1'b1;
            #1;
            check(imm_tab[i].name, mem_addr, imm_tab[i].imm);
            idle();
        end
        load_ir(32'h4020_8033);
        #1;
        check("funct7_sub", {25'd0, funct7}, 32'h20);

        // beq compare: equal then unequal operands.
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        load_ir(32'h0020_8463);
        tick();
        ALUSrcA = SRCA_A; ALUSrcB = SRCB_B; ALUControl = ALU_SUB; #1;
        check("beq_eq_zero", {31'd0, zero}, 32'h1);
        write_reg(5'd2, 32'd6);
        load_ir(32'h0020_8463);
        tick();
        ALUSrcA = SRCA_A; ALUSrcB = SRCB_B; ALUControl = ALU_SUB; #1;
        check("beq_ne_zero", {31'd0, zero}, 32'h0);
        idle();
`ifdef DP_DEBUG_PORT_EN
        dbg_raddr = 5'd2; #1;
        check("dbg_x2", dbg_rdata, 32'd6);
        dbg_raddr = 5'd0; #1;
        check("dbg_x0", dbg_rdata, 32'd0);
`endif

        // sw x2, 8(x1): address computed into ALUOut, then presented with MemWrite.
        write_reg(5'd1, 32'h0000_0100);
        write_reg(5'd2, 32'hDEAD_BEEF);
        load_ir(32'h0020_A423);
        tick();
        ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; ImmSrc = IMM_S; ALUControl = ALU_ADD;
        tick();
        idle();
        AddrSrc = 1'b1; ResultSrc = RES_ALUOUT; MemWrite = 1'b1; #1;
        check("sw_mem_we", {31'd0, mem_we}, 32'h1);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_addr", mem_addr, 32'h0000_0108);
        check("sw_funct3", {29'd0, funct3}, 32'h2);
        idle();

        // Same-cycle write and read of x3: old value first, new value next cycle.
        write_reg(5'd3, 32'h0000_0011);
        load_ir({12'd0, 5'd3, 3'd0, 5'd3, 7'h33});
        mem_rdata = 32'h0000_0099;
        tick();
        ResultSrc = RES_DATA; RegWrite = 1'b1;
        tick();
        idle();
        ALUSrcA = SRCA_A; ALUSrcB = SRCB_ZERO; ALUControl = ALU_ADD;
        ResultSrc = RES_ALURESULT; AddrSrc = 1'b1; #1;
        check("x3_old", mem_addr, 32'h0000_0011);
        tick();
        check("x3_new", mem_addr, 32'h0000_0099);
        idle();

        // Reset in the middle of a writeback aborts it and clears state.
        write_reg(5'd5, 32'h1234_5678);
        load_ir({20'd0, 5'd5, 7'h33});
        mem_rdata = 32'h0000_CAFE;
        tick();
        rst = 1'b0;
        ImmSrc = '1; ALUSrcA = '1; ALUSrcB = '1; ResultSrc = RES_DATA; AddrSrc = 1'b1;
        ALUControl = '1; IRWrite = 1'b1; RegWrite = 1'b1; MemWrite = 1'b1; PCWrite = 1'b1;
        tick();
        rst = 1'b1;
        idle();
        ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; #1;
        check("midrst_pc", mem_addr, 32'h0);
        check("midrst_op", {25'd0, op}, 32'h0);
        check("midrst_zero", {31'd0, zero}, 32'h0);
        idle();
        read_reg(5'd5, v);
        check("midrst_x5", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multi_cycle_datapath.md
MULTI_CYCLE_DATAPATH -- requirements
Module: multi_cycle_datapath

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Ports in from controller: ImmSrc 3, ALUSrcA 2, ALUSrcB 2, ResultSrc 2, AddrSrc 1, ALUControl 3, IRWrite 1, RegWrite 1, MemWrite 1, PCWrite 1.
REQ-005 Ports out to controller: op 7 = IR[6:0]; funct3 3 = IR[14:12]; funct7 7 = IR[31:25]; zero 1 = (ALUResult == 0).
REQ-006 Memory ports: mem_addr out 32; mem_wdata out 32; mem_we out 1; mem_rdata in 32, combinational read of mem_addr.

Function
REQ-007 Architectural/holding registers SHALL be PC, OldPC, IR, Data, A, B, ALUOut, plus a 32x32 register file.
REQ-008 PC SHALL load Result when PCWrite=1, else hold.
REQ-009 IR SHALL load mem_rdata and OldPC SHALL load current PC, both only when IRWrite=1.
REQ-010 Data, A (rs1 read), B (rs2 read), ALUOut (ALUResult) SHALL load every cycle unconditionally.
REQ-011 mem_addr SHALL be PC when AddrSrc=0, Result when AddrSrc=1; mem_wdata SHALL be B; mem_we SHALL equal MemWrite.
REQ-012 SrcA mux: 00 PC, 01 OldPC, 10 A, 11 zero.
REQ-013 SrcB mux: 00 B, 01 ImmExt, 10 constant 4, 11 zero.
REQ-014 ImmSrc: 000 I, 001 S, 010 B (bit0=0), 011 J (bit0=0), 100 U (IR[31:12]<<12); others yield zero; all sign-extended from IR[31].
REQ-015 ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 0/1), 110 sll, 111 srl; shifts use SrcB[4:0]; add/sub wrap modulo 2^32.
REQ-016 ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
REQ-017 Register file SHALL read rs1=IR[19:15], rs2=IR[24:20] combinationally and write Result to rd=IR[11:7] on rising edge when RegWrite=1.
REQ-018 x0 SHALL read zero always; writes to x0 SHALL be discarded.
REQ-019 Same-cycle write and read of one register SHALL return the old value (no bypass); new value visible next cycle.
REQ-020 PCWrite and IRWrite asserted together SHALL capture OldPC=old PC, IR=mem_rdata, PC=Result in the same edge.

Reset
REQ-021 When rst=0 at a rising edge: PC=RESET_PC; OldPC, IR, Data, A, B, ALUOut, all 31 writable registers = 0; control inputs ignored that edge.
REQ-022 Reset mid-instruction SHALL abort it with no RegWrite committed that edge; combinational outputs follow reset state next cycle (op=0, zero per current SrcA/SrcB).

Configuration
REQ-023 Macro DP_DEBUG_PORT_EN: when defined, ports dbg_raddr in 5 and dbg_rdata out 32 SHALL exist, giving a third combinational regfile read (x0 reads 0); when undefined, ports and read logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-024 Shared package SHALL hold ImmSrc, ALUSrcA/B, ResultSrc, ALUControl encodings and XLEN=32, shared with the controller.
REQ-025 Register file SHALL be a sub-module named regfile; ALU and immediate extender remain inline.

Verification
REQ-026 rst=0 one cycle with all controls high -> PC=RESET_PC, IR=0, x1..x31=0, mem_we=0 after release.
REQ-027 Fetch: PC=0, mem_rdata=32'h0050_0093 (addi x1,x0,5), IRWrite=PCWrite=1, SrcA=00, SrcB=10, ResultSrc=10 -> PC=4, OldPC=0, op=7'h13.
REQ-028 Execute addi: SrcA=10, SrcB=01, ImmSrc=000, ALUControl=000, next cycle ResultSrc=00, RegWrite=1 -> x1=5; x0 write of 7 -> x0 reads 0.
REQ-029 x1=5, x2=5, beq IR, SrcA=10, SrcB=00, ALUControl=001 -> zero=1; x2=6 -> zero=0.
REQ-030 sw with B=32'hDEAD_BEEF, AddrSrc=1, MemWrite=1 -> mem_we=1, mem_wdata=32'hDEAD_BEEF, mem_addr=ALUOut.
REQ-031 slt with A=32'hFFFF_FFFF, B=1 -> ALUResult=1; same-cycle write/read x3 -> old value returned, new value next cycle.
